// File: rtl/avalon_led_btn_pkg.sv
// Shared register map and address type for the LED/button Avalon-MM peripheral.
package avalon_led_btn_pkg;

  typedef logic [2:0] reg_addr_t;

  localparam reg_addr_t ADDR_LED_OUT   = 3'd0;
  localparam reg_addr_t ADDR_LED_MODE  = 3'd1;
  localparam reg_addr_t ADDR_PWM_DUTY  = 3'd2;
  localparam reg_addr_t ADDR_BTN_STATE = 3'd3;
  localparam reg_addr_t ADDR_BTN_EDGE  = 3'd4;
  localparam reg_addr_t ADDR_IRQ_MASK  = 3'd5;

endpackage

// File: rtl/btn_debounce.sv
// Single-button debouncer: synchronises an active-low raw input and only
// accepts a new level after it has been stable for DEBOUNCE_CYCLES cycles.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_n,
  output logic state,
  output logic rise_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // High in the cycle whose closing edge moves the debounced state from 0 to 1.
  assign rise_pulse = sync2 & ~state & (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      state <= 1'b0;
    end else begin
      sync1 <= ~raw_n;
      sync2 <= sync1;
      if (sync2 == state) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        state <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/avalon_led_btn_ctrl.sv
// Avalon-MM LED/button peripheral: static or PWM-dimmed LEDs, debounced
// buttons with press-edge capture and a maskable level interrupt.
module avalon_led_btn_ctrl #(
  parameter int NUM_LEDS        = 8,
  parameter int NUM_BTNS        = 4,
  parameter int PWM_BITS        = 8,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          avs_s0_address,
  input  logic                avs_s0_read,
  input  logic                avs_s0_write,
  input  logic [31:0]         avs_s0_writedata,
  output logic [31:0]         avs_s0_readdata,
  input  logic [NUM_BTNS-1:0] button_in_port,
  output logic [NUM_LEDS-1:0] leds,
  output logic                irq
);

  import avalon_led_btn_pkg::*;

  reg_addr_t           addr;
  logic [NUM_LEDS-1:0] led_out;
  logic [NUM_LEDS-1:0] led_mode;
  logic [PWM_BITS-1:0] pwm_duty;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pwm_on;
  logic [NUM_BTNS-1:0] btn_state;
  logic [NUM_BTNS-1:0] btn_rise;
  logic [NUM_BTNS-1:0] btn_edge;
  logic [NUM_BTNS-1:0] irq_mask;
  logic [NUM_BTNS-1:0] edge_clr;
  logic [31:0]         rd_mux;
  logic                unused_wdata;

  assign addr         = avs_s0_address;
  assign pwm_on       = (pwm_cnt < pwm_duty);
  assign unused_wdata = &{1'b0, avs_s0_writedata};

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk       (clk),
      .reset     (reset),
      .raw_n     (button_in_port[i]),
      .state     (btn_state[i]),
      .rise_pulse(btn_rise[i])
    );
  end

  always_comb begin
    edge_clr = '0;
    if (avs_s0_write && addr == ADDR_BTN_EDGE) begin
      edge_clr = avs_s0_writedata[NUM_BTNS-1:0];
    end
  end

  // A new press in the same cycle as a W1C write keeps the bit set.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_out  <= '0;
      led_mode <= '0;
      pwm_duty <= '0;
      irq_mask <= '0;
      btn_edge <= '0;
    end else begin
      if (avs_s0_write) begin
        case (addr)
          ADDR_LED_OUT:  led_out  <= avs_s0_writedata[NUM_LEDS-1:0];
          ADDR_LED_MODE: led_mode <= avs_s0_writedata[NUM_LEDS-1:0];
          ADDR_PWM_DUTY: pwm_duty <= avs_s0_writedata[PWM_BITS-1:0];
          ADDR_IRQ_MASK: irq_mask <= avs_s0_writedata[NUM_BTNS-1:0];
          default: ;
        endcase
      end
      btn_edge <= (btn_edge & ~edge_clr) | btn_rise;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= '0;
      leds    <= '0;
      irq     <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      leds    <= led_out & (~led_mode | {NUM_LEDS{pwm_on}});
      irq     <= |(btn_edge & irq_mask);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_LED_OUT:   rd_mux[NUM_LEDS-1:0] = led_out;
      ADDR_LED_MODE:  rd_mux[NUM_LEDS-1:0] = led_mode;
      ADDR_PWM_DUTY:  rd_mux[PWM_BITS-1:0] = pwm_duty;
      ADDR_BTN_STATE: rd_mux[NUM_BTNS-1:0] = btn_state;
      ADDR_BTN_EDGE:  rd_mux[NUM_BTNS-1:0] = btn_edge;
      ADDR_IRQ_MASK:  rd_mux[NUM_BTNS-1:0] = irq_mask;
      default: ;
    endcase
  end

  // Read data samples pre-write register contents and holds between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      avs_s0_readdata <= '0;
    end else if (avs_s0_read) begin
      avs_s0_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_avalon_led_btn_ctrl.sv
// Directed self-checking bench for avalon_led_btn_ctrl with a read scoreboard.
module tb_avalon_led_btn_ctrl;

  localparam int NUM_LEDS = 8;
  localparam int NUM_BTNS = 4;
  localparam int PWM_BITS = 8;
  localparam int DEB      = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [2:0]          avs_s0_address;
  logic                avs_s0_read;
  logic                avs_s0_write;
  logic [31:0]         avs_s0_writedata;
  logic [31:0]         avs_s0_readdata;
  logic [NUM_BTNS-1:0] button_in_port;
  logic [NUM_LEDS-1:0] leds;
  logic                irq;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  avalon_led_btn_ctrl #(
    .NUM_LEDS       (NUM_LEDS),
    .NUM_BTNS       (NUM_BTNS),
    .PWM_BITS       (PWM_BITS),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .avs_s0_address  (avs_s0_address),
    .avs_s0_read     (avs_s0_read),
    .avs_s0_write    (avs_s0_write),
    .avs_s0_writedata(avs_s0_writedata),
    .avs_s0_readdata (avs_s0_readdata),
    .button_in_port  (button_in_port),
    .leds            (leds),
    .irq             (irq)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_BTNS-1:0] btns, input int cycles);
    button_in_port = btns;
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic busWrite(input logic [2:0] a, input logic [31:0] d);
    avs_s0_address   = a;
    avs_s0_writedata = d;
    avs_s0_write     = 1'b1;
    step();
    avs_s0_write     = 1'b0;
  endtask

  task automatic busRead(input logic [2:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] e;
    string       t;
    avs_s0_address = a;
    avs_s0_read    = 1'b1;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    step();
    avs_s0_read = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checkOutput(t, avs_s0_readdata, e);
    end
  endtask

  task automatic countPwm(output int ones, output int bad_upper);
    ones      = 0;
    bad_upper = 0;
    for (int i = 0; i < 256; i++) begin
      if (leds[0]) ones++;
      if (leds[7:1] !== 7'h7F) bad_upper++;
      step();
    end
  endtask

  initial begin
    int ones;
    int bad;
    int irq_seen;
    int budget;

    reset            = 1'b1;
    avs_s0_address   = '0;
    avs_s0_read      = 1'b0;
    avs_s0_write     = 1'b0;
    avs_s0_writedata = '0;
    button_in_port   = '1;
    step(); step(); step();
    reset = 1'b0;

    checkOutput("reset_leds", 32'(leds), 32'h0);
    checkOutput("reset_irq", 32'(irq), 32'h0);
    checkOutput("reset_rdata", avs_s0_readdata, 32'h0);
    for (int a = 0; a < 8; a++) busRead(3'(a), 32'h0, $sformatf("reset_read_addr%0d", a));

    // Static LED path and register readback
    busWrite(3'd0, 32'h0000_00A5);
    checkOutput("leds_latency1", 32'(leds), 32'h0);
    step();
    checkOutput("leds_static", 32'(leds), 32'hA5);
    busRead(3'd0, 32'h0000_00A5, "read_led_out");
    busWrite(3'd0, 32'hFFFF_FF5A);
    busRead(3'd0, 32'h0000_005A, "led_out_upper_ignored");
    busWrite(3'd6, 32'hFFFF_FFFF);
    busRead(3'd6, 32'h0, "addr6_reads_zero");
    busRead(3'd3, 32'h0, "btn_state_ro_idle");

    // Simultaneous read and write returns the old value
    avs_s0_address   = 3'd5;
    avs_s0_writedata = 32'h3;
    avs_s0_write     = 1'b1;
    avs_s0_read      = 1'b1;
    exp_q.push_back(32'h0);
    tag_q.push_back("rw_same_cycle_old");
    step();
    avs_s0_write = 1'b0;
    avs_s0_read  = 1'b0;
    checkOutput(tag_q.pop_front(), avs_s0_readdata, exp_q.pop_front());
    busRead(3'd5, 32'h3, "rw_same_cycle_new");
    busWrite(3'd5, 32'h0);

    // PWM on LED 0 with several duty values
    busWrite(3'd0, 32'hFF);
    busWrite(3'd1, 32'h01);
    busWrite(3'd2, 32'd64);
    busRead(3'd2, 32'd64, "read_pwm_duty");
    step();
    countPwm(ones, bad);
    checkOutput("pwm64_on_cycles", 32'(ones), 32'd64);
    checkOutput("pwm64_upper_static", 32'(bad), 32'd0);
    busWrite(3'd2, 32'd0);
    step(); step();
    countPwm(ones, bad);
    checkOutput("pwm0_on_cycles", 32'(ones), 32'd0);
    busWrite(3'd2, 32'd255);
    step(); step();
    countPwm(ones, bad);
    checkOutput("pwm255_on_cycles", 32'(ones), 32'd255);
    busWrite(3'd1, 32'h0);

    // Short glitch on button 2 must not register
    applyStimulus(4'b1011, 3);
    applyStimulus(4'b1111, 10);
    busRead(3'd3, 32'h0, "glitch_state");
    busRead(3'd4, 32'h0, "glitch_edge");

    // Long press with IRQ masked off
    applyStimulus(4'b1011, 10);
    busRead(3'd3, 32'h4, "press_state");
    busRead(3'd4, 32'h4, "press_edge");
    irq_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (irq) irq_seen++;
      step();
    end
    checkOutput("masked_irq_low", 32'(irq_seen), 32'd0);
    applyStimulus(4'b1111, 10);
    busRead(3'd3, 32'h0, "release_state");
    busRead(3'd4, 32'h4, "release_not_captured");
    busWrite(3'd4, 32'h4);
    busRead(3'd4, 32'h0, "w1c_clears");

    // Unmasked press raises irq; W1C drops it one cycle later
    busWrite(3'd5, 32'h4);
    applyStimulus(4'b1011, 0);
    budget = 30;
    while (!irq && budget > 0) begin
      step();
      budget--;
    end
    checkOutput("irq_rise", 32'(irq), 32'h1);
    busWrite(3'd4, 32'h4);
    checkOutput("irq_hold_after_w1c", 32'(irq), 32'h1);
    step();
    checkOutput("irq_clear", 32'(irq), 32'h0);
    applyStimulus(4'b1111, 10);

    // Debounced press lands in the same cycle as a W1C of that bit
    busRead(3'd4, 32'h0, "pre_collision_edge");
    applyStimulus(4'b1011, 5);
    busWrite(3'd4, 32'h4);
    step();
    checkOutput("collision_irq", 32'(irq), 32'h1);
    busRead(3'd4, 32'h4, "collision_edge_set_wins");
    busRead(3'd3, 32'h4, "collision_state");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
